// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the processing-element datapath.
package pe_pkg;

  localparam int unsigned ACC_W = 64;

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StAccum = 2'd1;
  localparam state_t StHold  = 2'd2;

endpackage

// File: rtl/sat_add64.sv
// Signed two's-complement adder that clamps to the representable range on overflow.
module sat_add64
  import pe_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only when both operands share a sign and the result flips it.
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    sum = raw;
    if (ovf) begin
      sum = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a programmed number of signed products into a saturating 64-bit sum
// and holds the result until the consumer takes it.
module mac_accumulator
  import pe_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [ACC_W-1:0]  prod,
  input  logic              acc_start,
  input  logic [LEN_W-1:0]  len,
  input  logic              out_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  output logic              busy,
  output logic              start_err,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                sat_q, sat_d;
  logic                start_err_q, start_err_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [ACC_W-1:0]    sum;
  logic                ovf;
  logic                accept;

  sat_add64 u_sat_add (
    .a   (acc_q),
    .b   (prod),
    .sum (sum),
    .ovf (ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    sat_d       = sat_q;
    start_err_d = 1'b0;
    drop_d      = drop_q;
    accept      = acc_start && ((state_q == StIdle) || ((state_q == StHold) && out_ready));

    case (state_q)
      StIdle: begin
        if (prod_valid && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
      end
      StAccum: begin
        if (acc_start) start_err_d = 1'b1;
        if (prod_valid) begin
          acc_d = sum;
          sat_d = sat_q | ovf;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = StHold;
        end
      end
      StHold: begin
        if (prod_valid && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
        if (out_ready)      state_d     = StIdle;
        else if (acc_start) start_err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A length of zero skips accumulation and presents an all-zero result directly.
    if (accept) begin
      acc_d   = '0;
      sat_d   = 1'b0;
      rem_d   = len;
      state_d = (len != '0) ? StAccum : StHold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      rem_q       <= '0;
      sat_q       <= 1'b0;
      start_err_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      sat_q       <= sat_d;
      start_err_q <= start_err_d;
      drop_q      <= drop_d;
    end
  end

  assign res_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign res_data  = acc_q;
  assign res_sat   = sat_q;
  assign start_err = start_err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter LEN_W, default 8: width of the dot-product length field.
REQ-002 Parameter DROP_W, default 8: width of the dropped-product counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 prod_valid  input  1  product strobe from the upstream booth_wallace_multiplier_seq valid output.
REQ-006 prod  input  64  signed product from the upstream multiplier P output.
REQ-007 acc_start  input  1  request to begin a new accumulation.
REQ-008 len  input  LEN_W  number of products to accumulate, unsigned, sampled with acc_start.
REQ-009 out_ready  input  1  downstream consumer accepts the result.
REQ-010 res_valid  output  1  result available.
REQ-011 res_data  output  64  signed accumulated sum.
REQ-012 res_sat  output  1  result was clamped at least once.
REQ-013 busy  output  1  high in ACCUM and HOLD.
REQ-014 start_err  output  1  one-cycle pulse when acc_start is rejected.
REQ-015 drop_cnt  output  DROP_W  saturating count of discarded products.

Function
REQ-016 FSM states SHALL be IDLE, ACCUM and HOLD; busy SHALL be 1 when the state is not IDLE.
REQ-017 IDLE with acc_start and len!=0 SHALL go to ACCUM, clear acc and res_sat, and load remaining=len.
REQ-018 IDLE with acc_start and len==0 SHALL go to HOLD with res_data=0, res_sat=0.
REQ-019 ACCUM with prod_valid SHALL set acc=sat_add(acc,prod) and decrement remaining; no prod_valid holds all state.
REQ-020 ACCUM with prod_valid and remaining==1 SHALL go to HOLD, with res_data equal to the final saturated sum on the next cycle (latency 1 clock after the last product).
REQ-021 sat_add SHALL be a signed 64-bit add; on positive overflow the result SHALL be 0x7FFF_FFFF_FFFF_FFFF, on negative overflow 0x8000_0000_0000_0000, and any clamp SHALL set res_sat sticky for the current result.
REQ-022 HOLD SHALL drive res_valid=1 with res_data and res_sat stable until a cycle with out_ready=1.
REQ-023 HOLD with out_ready=1 and acc_start=0 SHALL go to IDLE; res_valid SHALL be 0 the following cycle.
REQ-024 HOLD with out_ready=1 and acc_start=1 SHALL accept the start exactly as in IDLE (back-to-back, no idle bubble).
REQ-025 acc_start in ACCUM, or in HOLD without out_ready, SHALL be ignored and SHALL pulse start_err for one cycle.
REQ-026 prod_valid in IDLE or HOLD SHALL discard the product and increment drop_cnt, which saturates at all-ones.
REQ-027 res_data and res_sat SHALL be registered outputs; res_valid SHALL be 1 only in HOLD.

Reset
REQ-028 rst SHALL force IDLE, acc=0, remaining=0, res_data=0, res_sat=0, res_valid=0, busy=0, start_err=0 and drop_cnt=0 on the next edge; rst takes priority over every input.
REQ-029 rst asserted mid-ACCUM or mid-HOLD SHALL abandon the result with no res_valid pulse.

Structure
REQ-030 A shared package pe_pkg SHALL hold the state enum, ACC_W=64, SAT_MAX and SAT_MIN.
REQ-031 Saturating addition SHALL be one combinational sub-module sat_add64 (inputs a, b; outputs sum, ovf).
REQ-032 Implementation SHALL be a single registered FSM with a datapath, with no combinational path from prod to res_data.

Verification
REQ-033 len=3, products 2, 3, -1 on consecutive cycles -> res_valid=1 the cycle after the third product, res_data=4, res_sat=0.
REQ-034 len=2, products 0x7FFF_FFFF_FFFF_FFFF then 5 -> res_data=0x7FFF_FFFF_FFFF_FFFF, res_sat=1; a following len=2 run with products -1, -1 -> res_data=-2, res_sat=0.
REQ-035 acc_start with len=0 -> res_valid next cycle, res_data=0; out_ready=1 -> IDLE.
REQ-036 HOLD with out_ready=0 for 5 cycles plus 2 prod_valid pulses and 1 acc_start -> res_data stable, drop_cnt=2, one start_err pulse.
REQ-037 HOLD with out_ready=1 and acc_start=1 (len=1), then product 7 -> second res_valid carries 7 with no IDLE cycle in between.
REQ-038 rst after 2 of 4 products -> IDLE with all outputs 0 next cycle; a fresh len=1 run with product 9 -> res_data=9.
